word_tx_serializer: RTL and testbench
=====================================

// Module: word_tx_serializer
// PURPOSE
//  Downstream of the debug send path: takes one NBITS-wide word (tx_Data/tx_start) and
//  emits it as NBITS/8 bytes, LSB byte first, to the byte-wide UART transmitter.
//  Handshakes each byte with the UART (byte_start/byte_done) and pulses tx_done once
//  the whole word has been sent, so the debug sender can present the next word.
// PARAMETERS
//  NBITS    32  word width; must be a multiple of 8 (elaboration error otherwise)
//  BYTE_W   8   UART byte width (fixed at 8; parameter for readability only)
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  reset       in   1       synchronous, active-high reset
//  tx_Data     in   NBITS   word to transmit, sampled only when accepted
//  tx_start    in   1       1-cycle request; accepted only in IDLE
//  tx_done     out  1       1-cycle pulse: whole word (and checksum if enabled) sent
//  busy        out  1       high from acceptance until the cycle tx_done is high
//  byte_Data   out  8       byte presented to UART tx; stable while byte_start/WAIT
//  byte_start  out  1       1-cycle pulse launching one UART byte
//  byte_done   in   1       1-cycle pulse from UART tx: current byte fully shifted out
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, tx_done=0, busy=0, byte_start=0,
//    byte_Data=8'h00, shift reg=0, byte count=0, checksum=0.
//  - States: IDLE, SEND, WAIT (+ CSUM with macro).
//  - IDLE: tx_start=1 -> latch tx_Data into shift reg, cnt=0, busy=1, -> SEND.
//  - SEND: byte_Data<=shift[7:0], byte_start<=1 for exactly one cycle, -> WAIT.
//  - WAIT: hold byte_Data; on byte_done: shift>>=8, cnt++; if cnt was NBITS/8-1 ->
//    last byte done (-> IDLE, tx_done<=1, busy<=0), else -> SEND.
//  - Latency: tx_start sampled at edge N -> byte_start high after edge N+1.
//    byte_done sampled at edge M -> next byte_start high after edge M+1.
//  - Back-to-back: tx_start in the same cycle tx_done is high is accepted (FSM is in IDLE).
//  - tx_start while busy: ignored, no queueing, tx_Data not re-sampled.
//  - byte_done outside WAIT (IDLE/SEND): ignored.
//  - Stalled UART: WAIT held indefinitely; byte_start never re-asserted; no timeout.
//  - Counter width clog2(NBITS/8)+1; no wrap beyond last byte index.
//  - Reset mid-word: abort immediately, no tx_done, remaining bytes discarded.
// CONFIGURATION
//  WORD_TX_CHECKSUM_EN defined: running XOR of all sent bytes (cleared on accept);
//    after last data byte_done -> CSUM: byte_Data<=XOR, byte_start pulse, wait
//    byte_done, then tx_done/IDLE. Word costs NBITS/8+1 UART bytes.
//  Not defined: no CSUM state, no checksum register; tx_done after last data byte.
// STRUCTURE
//  - Shared package uart_pkg: state enum (IDLE,SEND,WAIT,CSUM), BYTE_W=8,
//    NBYTES=NBITS/8 helper, count-width function.
//  - Single flat module; no sub-module (shift reg + counter + FSM are small).
// TESTING
//  1 tx_Data=32'hDEADBEEF, tx_start, byte_done 10 cyc after each byte_start ->
//    byte_Data EF,BE,AD,DE; 4 byte_start pulses; one tx_done after 4th byte_done.
//  2 tx_start=1 with tx_Data=32'h12345678 while sending word from test 1 ->
//    ignored; bytes still EF,BE,AD,DE; exactly one tx_done.
//  3 tx_start (32'hA5A5A5A5) in same cycle as tx_done -> accepted; A5 x4 then tx_done.
//  4 reset asserted in WAIT after 2nd byte -> next cycle busy=0, byte_start=0,
//    byte_Data=00; no tx_done; fresh 32'h00000001 then sends 01,00,00,00.
//  5 hold byte_done low 1000 cycles in WAIT -> byte_start stays 0, byte_Data stable,
//    busy=1; spurious byte_done in IDLE -> no effect.
//  6 WORD_TX_CHECKSUM_EN, 32'hDEADBEEF -> EF,BE,AD,DE,22; tx_done after 5th byte_done.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the byte-oriented UART transmit path.
//   - state_t   : word serializer FSM states (CSUM used only with checksum build)
//   - BYTE_W    : UART byte width
//   - nbytes()  : number of UART bytes in an NBITS-wide word
//   - cnt_width(): byte counter width for an NBITS-wide word
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    CSUM = 2'd3
  } state_t;

  function automatic int nbytes(input int nbits);
    return nbits / BYTE_W;
  endfunction

  // One spare bit so the counter can hold the checksum slot index (NBYTES).
  function automatic int cnt_width(input int nbits);
    return $clog2(nbytes(nbits)) + 1;
  endfunction

endpackage

// File: rtl/word_tx_serializer.sv
// -----------------------------------------------------------------------------
// word_tx_serializer
//   Splits one NBITS-wide word into NBITS/8 bytes, LSB byte first, and hands
//   them one at a time to a byte-wide UART transmitter using a
//   byte_start / byte_done handshake. tx_done pulses once the word is out.
//
//   Build option: define WORD_TX_CHECKSUM_EN to append one XOR checksum byte
//   of all data bytes after the last data byte (word = NBITS/8+1 UART bytes).
//
// Ports
//   clk         in   1       system clock, rising edge
//   reset       in   1       synchronous active-high reset
//   tx_Data     in   NBITS   word to send, sampled only on acceptance
//   tx_start    in   1       request; accepted only when idle
//   tx_done     out  1       1-cycle pulse: whole word sent
//   busy        out  1       high from acceptance until tx_done cycle
//   byte_Data   out  BYTE_W  byte presented to the UART, held until byte_done
//   byte_start  out  1       1-cycle pulse launching one UART byte
//   byte_done   in   1       1-cycle pulse: UART finished current byte
// -----------------------------------------------------------------------------
module word_tx_serializer
  import uart_pkg::*;
#(
  parameter int NBITS  = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NBITS-1:0]  tx_Data,
  input  logic              tx_start,
  output logic              tx_done,
  output logic              busy,
  output logic [BYTE_W-1:0] byte_Data,
  output logic              byte_start,
  input  logic              byte_done
);

  localparam int NBYTES = nbytes(NBITS);
  localparam int CNT_W  = cnt_width(NBITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

  if ((NBITS % 8) != 0 || NBITS < 8) begin : g_bad_nbits
    $error("word_tx_serializer: NBITS must be a non-zero multiple of 8");
  end
  if (BYTE_W != 8) begin : g_bad_byte_w
    $error("word_tx_serializer: BYTE_W is fixed at 8");
  end

  state_t            state_q, state_d;
  logic [NBITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [BYTE_W-1:0] byte_data_d;
  logic              byte_start_d;
  logic              tx_done_d;
  logic              busy_d;
  logic              word_end;

`ifdef WORD_TX_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;
  // Checksum byte occupies the slot after the last data byte.
  localparam logic [CNT_W-1:0] FINAL_IDX = CNT_W'(NBYTES);
`else
  localparam logic [CNT_W-1:0] FINAL_IDX = LAST_IDX;
`endif

  // UART acknowledged the final byte of this word (data or checksum).
  assign word_end = (state_q == WAIT) && byte_done && (cnt_q == FINAL_IDX);

  // State and datapath registers
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      byte_Data  <= '0;
      byte_start <= 1'b0;
      tx_done    <= 1'b0;
      busy       <= 1'b0;
`ifdef WORD_TX_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      byte_Data  <= byte_data_d;
      byte_start <= byte_start_d;
      tx_done    <= tx_done_d;
      busy       <= busy_d;
`ifdef WORD_TX_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Next-state logic
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (tx_start) state_d = SEND;
      SEND: state_d = WAIT;
      WAIT: begin
        if (byte_done) begin
          if (word_end)                state_d = IDLE;
`ifdef WORD_TX_CHECKSUM_EN
          else if (cnt_q == LAST_IDX)  state_d = CSUM;
`endif
          else                         state_d = SEND;
        end
      end
`ifdef WORD_TX_CHECKSUM_EN
      CSUM: state_d = WAIT;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Registered-output and datapath next values
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    byte_data_d  = byte_Data;
    byte_start_d = 1'b0;
    tx_done_d    = 1'b0;
    busy_d       = busy;
`ifdef WORD_TX_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d = tx_Data;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef WORD_TX_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      SEND: begin
        byte_data_d  = shift_q[BYTE_W-1:0];
        byte_start_d = 1'b1;
`ifdef WORD_TX_CHECKSUM_EN
        csum_d       = csum_q ^ shift_q[BYTE_W-1:0];
`endif
      end
      WAIT: begin
        if (byte_done) begin
          shift_d = shift_q >> BYTE_W;
          if (word_end) begin
            tx_done_d = 1'b1;
            busy_d    = 1'b0;
          end else begin
            // Counter stops at the final index instead of wrapping.
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`ifdef WORD_TX_CHECKSUM_EN
      CSUM: begin
        byte_data_d  = csum_q;
        byte_start_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_word_tx_serializer.sv
// -----------------------------------------------------------------------------
// tb_word_tx_serializer
//   Scoreboard bench for word_tx_serializer. The driver pushes the expected
//   byte stream (and a word-end marker) for every accepted word; an
//   independent monitor pops and compares on each byte_start / tx_done.
//   A UART responder process answers byte_start with byte_done.
//   Define WORD_TX_CHECKSUM_EN for both DUT and bench to cover the checksum.
// -----------------------------------------------------------------------------
module tb_word_tx_serializer;

  localparam int NBITS    = 32;
  localparam int NB       = NBITS / 8;
  localparam int WAIT_LIM = 2000;

  logic             clk = 1'b0;
  logic             reset;
  logic [NBITS-1:0] tx_Data;
  logic             tx_start;
  logic             tx_done;
  logic             busy;
  logic [7:0]       byte_Data;
  logic             byte_start;
  logic             byte_done;

  word_tx_serializer #(.NBITS(NBITS), .BYTE_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_Data    (tx_Data),
    .tx_start   (tx_start),
    .tx_done    (tx_done),
    .busy       (busy),
    .byte_Data  (byte_Data),
    .byte_start (byte_start),
    .byte_done  (byte_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int due    = -1;   // cycle at which the next byte_start must be visible
  int last_bd = -1;  // cycle at which the responder last drove byte_done
  int n_bs = 0, n_done = 0;
  int exp_bs = 0, exp_done = 0;
  bit uart_en;
  int uart_delay;    // 0 = random delay per byte

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the byte sequence a word must produce on the UART side.
  task automatic model_push(input logic [NBITS-1:0] w);
    exp_t e;
    logic [7:0] x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      e.is_done = 1'b0;
      e.data    = 8'((w >> (8 * i)) & 32'hFF);
      x         = x ^ e.data;
      sb.push_back(e);
      exp_bs++;
    end
`ifdef WORD_TX_CHECKSUM_EN
    e.is_done = 1'b0;
    e.data    = x;
    sb.push_back(e);
    exp_bs++;
`endif
    e.is_done = 1'b1;
    e.data    = 8'h00;
    sb.push_back(e);
    exp_done++;
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (byte_start) begin
        n_bs++;
        check("byte_start_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("byte_not_word_end", 32'(e.is_done), 32'd0);
          check("byte_data", 32'(byte_Data), 32'(e.data));
          check("byte_start_latency", cyc, due);
          check("busy_during_byte", 32'(busy), 32'd1);
        end
      end
      if (tx_done) begin
        n_done++;
        check("tx_done_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("tx_done_at_word_end", 32'(e.is_done), 32'd1);
          check("tx_done_latency", cyc, last_bd + 1);
          check("busy_low_at_tx_done", 32'(busy), 32'd0);
        end
      end
    end
  end

  // UART responder
  initial begin
    int d;
    byte_done = 1'b0;
    forever begin
      @(negedge clk);
      if (byte_start && uart_en) begin
        d = (uart_delay > 0) ? uart_delay : int'($urandom_range(2, 12));
        repeat (d - 1) @(negedge clk);
        if (uart_en) begin
          byte_done = 1'b1;
          last_bd   = cyc;
          due       = cyc + 2;
          @(negedge clk);
          byte_done = 1'b0;
        end
      end
    end
  end

  // Issue a word at the current negedge (DUT expected idle).
  task automatic start_word(input logic [NBITS-1:0] w);
    tx_Data  = w;
    tx_start = 1'b1;
    model_push(w);
    due = cyc + 2;
  endtask

  // Run until tx_done is visible; optionally poke ignored tx_start requests
  // and a spurious byte_done while the word is in flight.
  task automatic finish_word(input bit inject, input logic [NBITS-1:0] inj_data, input bit spur);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
      if (inject && t <= 3) begin
        tx_start = 1'b1;
        tx_Data  = inj_data;
      end else begin
        tx_start = 1'b0;
        tx_Data  = $urandom;
      end
      if (spur && t == 1) byte_done = 1'b1;
      if (spur && t == 2) byte_done = 1'b0;
    end while (!tx_done && t < WAIT_LIM);
    tx_start = 1'b0;
    check("tx_done_within_bound", 32'(tx_done), 32'd1);
  endtask

  initial begin
    int t;
    int seen;
    int bad;
    logic [NBITS-1:0] w;

    reset      = 1'b1;
    tx_start   = 1'b0;
    tx_Data    = '0;
    uart_en    = 1'b1;
    uart_delay = 10;
    repeat (3) @(negedge clk);
    check("reset_tx_done", 32'(tx_done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_byte_start", 32'(byte_start), 32'd0);
    check("reset_byte_data", 32'(byte_Data), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic word, UART answers 10 cycles after each byte_start.
    start_word(32'hDEADBEEF);
    finish_word(1'b0, '0, 1'b0);
    repeat (3) @(negedge clk);

    // Request while busy must be ignored; tx_Data not re-sampled.
    start_word(32'hDEADBEEF);
    finish_word(1'b1, 32'h12345678, 1'b0);

    // Back-to-back: new request in the tx_done cycle is accepted.
    start_word(32'hA5A5A5A5);
    finish_word(1'b0, '0, 1'b1);
    repeat (2) @(negedge clk);

    // Reset while waiting on the 2nd byte: abort, no tx_done.
    uart_delay = 4;
    start_word(32'h0BADF00D);
    seen = 0;
    t    = 0;
    do begin
      @(negedge clk);
      tx_start = 1'b0;
      t++;
      if (byte_start) seen++;
    end while (seen < 2 && t < WAIT_LIM);
    uart_en = 1'b0;
    check("abort_second_byte_seen", 32'(seen), 32'd2);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    foreach (sb[i]) if (!sb[i].is_done) exp_bs--;
    exp_done--;
    sb.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_byte_start", 32'(byte_start), 32'd0);
    check("abort_byte_data", 32'(byte_Data), 32'd0);
    check("abort_tx_done", 32'(tx_done), 32'd0);
    reset   = 1'b0;
    uart_en = 1'b1;
    repeat (3) @(negedge clk);
    start_word(32'h00000001);
    finish_word(1'b0, '0, 1'b0);
    repeat (2) @(negedge clk);

    // Stalled UART: WAIT held, no re-launch, byte held, still busy.
    uart_en = 1'b0;
    w = $urandom;
    start_word(w);
    t = 0;
    do begin
      @(negedge clk);
      tx_start = 1'b0;
      t++;
    end while (!byte_start && t < WAIT_LIM);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (byte_start || byte_Data !== w[7:0] || busy !== 1'b1) bad++;
    end
    check("stall_hold", 32'(bad), 32'd0);
    byte_done = 1'b1;
    last_bd   = cyc;
    due       = cyc + 2;
    @(negedge clk);
    byte_done = 1'b0;
    uart_en   = 1'b1;
    finish_word(1'b0, '0, 1'b0);

    // Spurious byte_done while idle: nothing may happen.
    repeat (3) begin
      @(negedge clk);
      byte_done = 1'b1;
      @(negedge clk);
      byte_done = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("idle_after_spurious_busy", 32'(busy), 32'd0);

    // Randomized traffic.
    uart_delay = 0;
    for (int n = 0; n < 24; n++) begin
      t = $urandom_range(0, 3);
      repeat (t) @(negedge clk);
      start_word($urandom);
      finish_word(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("byte_start_count", 32'(n_bs), 32'(exp_bs));
    check("tx_done_count", 32'(n_done), 32'(exp_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
